// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU among NREQ requesters.
// Each accepted request has its operands registered, is evaluated for one
// cycle, and its result/zero flag is then held until the owner accepts it.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins) instead of the default round-robin arbitration.

// Single-cycle combinational ALU; unknown opcodes produce zero.
module alu (
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [3:0]  alu_op_i,
    output logic [31:0] result_o,
    output logic        zero_o
);
    localparam int unsigned DW = 32;

    // Opcode decode; shift amounts use the low 5 bits of operand 2.
    always_comb begin
        result_o = '0;
        case (alu_op_i)
            4'h0:    result_o = op1_i & op2_i;
            4'h1:    result_o = op1_i | op2_i;
            4'h2:    result_o = op1_i + op2_i;
            4'h6:    result_o = op1_i - op2_i;
            4'h7:    result_o = {(DW-1)'(0), ($signed(op1_i) < $signed(op2_i))};
            4'h8:    result_o = op1_i >> op2_i[4:0];
            4'h9:    result_o = op1_i << op2_i[4:0];
            4'hA:    result_o = $unsigned($signed(op1_i) >>> op2_i[4:0]);
            4'hD:    result_o = op1_i ^ op2_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);
endmodule

module alu_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [32*NREQ-1:0]  req_op1,
    input  logic [32*NREQ-1:0]  req_op2,
    input  logic [4*NREQ-1:0]   req_alu_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [31:0]         rsp_result,
    output logic                rsp_zero,
    output logic                busy
);
    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     op1_q, op1_d;
    logic [DW-1:0]     op2_q, op2_d;
    logic [OPW-1:0]    alu_op_q, alu_op_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic [IDW-1:0]    grant_c;
    logic              grant_vld_c;
    logic [DW-1:0]     alu_result;
    logic              alu_zero;

    logic [DW-1:0]     op1_arr    [NREQ];
    logic [DW-1:0]     op2_arr    [NREQ];
    logic [OPW-1:0]    alu_op_arr [NREQ];

    // Unpack the flat requester buses into per-requester arrays.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op1_arr[gi]    = req_op1[DW*gi +: DW];
        assign op2_arr[gi]    = req_op2[DW*gi +: DW];
        assign alu_op_arr[gi] = req_alu_op[OPW*gi +: OPW];
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest valid index wins.
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!grant_vld_c && req_valid[IDW'(k)]) begin
                grant_c     = IDW'(k);
                grant_vld_c = 1'b1;
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] rr_idx;

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Pointer moves to the slot after the winner on every accepted request.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && grant_vld_c) begin
            rr_ptr_d = IDW'((int'(grant_c) + 1) % int'(NREQ));
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_c     = '0;
        grant_vld_c = 1'b0;
        rr_idx      = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            rr_idx = IDW'((int'(rr_ptr_q) + k) % int'(NREQ));
            if (!grant_vld_c && req_valid[rr_idx]) begin
                grant_c     = rr_idx;
                grant_vld_c = 1'b1;
            end
        end
    end
`endif

    // Accept strobe goes only to the winner, and only while idle and out of reset.
    assign req_ready = (rst_n && state_q == IDLE && grant_vld_c) ? (NREQ'(1) << grant_c) : '0;

    alu u_alu (
        .op1_i    (op1_q),
        .op2_i    (op2_q),
        .alu_op_i (alu_op_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op1_q        <= '0;
            op2_q        <= '0;
            alu_op_q     <= '0;
            owner_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            alu_op_q     <= alu_op_d;
            owner_q      <= owner_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    // Next-state: accept in IDLE, capture ALU output in EXEC, wait for owner in RESP.
    always_comb begin
        state_d      = state_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        alu_op_d     = alu_op_q;
        owner_d      = owner_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (grant_vld_c) begin
                    op1_d    = op1_arr[grant_c];
                    op2_d    = op2_arr[grant_c];
                    alu_op_d = alu_op_arr[grant_c];
                    owner_d  = grant_c;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_valid_d  = NREQ'(1) << owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a cycle model predicts grants and
// pushes expected results into a scoreboard that is popped on each response.
module tb_alu_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int M_IDLE = 0;
    localparam int M_EXEC = 1;
    localparam int M_RESP = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_op1;
    logic [32*NREQ-1:0]  req_op2;
    logic [4*NREQ-1:0]   req_alu_op;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         rsp_result;
    logic                rsp_zero;
    logic                busy;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_state  = M_IDLE;
    int   m_rr     = 0;
    bit   seen     = 1'b0;
    int   mon_g;
    int   mon_idx;
    logic [NREQ-1:0] mon_rdy;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_alu_op (req_alu_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: return a >> b[4:0];
            4'h9: return a << b[4:0];
            4'hA: return $unsigned($signed(a) >>> b[4:0]);
            4'hD: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model and scoreboard, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_req_ready", 32'(req_ready), 0);
            check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
            check_eq("rst_rsp_result", rsp_result, 0);
            check_eq("rst_rsp_zero", 32'(rsp_zero), 0);
            check_eq("rst_busy", 32'(busy), 0);
            m_state = M_IDLE;
            m_rr    = 0;
            seen    = 1'b0;
            sb.delete();
        end else begin
            mon_g = -1;
            if (m_state == M_IDLE) begin
                for (int k = 0; k < int'(NREQ); k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    mon_idx = k;
`else
                    mon_idx = (m_rr + k) % int'(NREQ);
`endif
                    if (mon_g < 0 && req_valid[mon_idx]) mon_g = mon_idx;
                end
            end
            mon_rdy = (mon_g >= 0) ? NREQ'(1) << mon_g : '0;
            check_eq("req_ready", 32'(req_ready), 32'(mon_rdy));
            check_eq("busy", 32'(busy), (m_state != M_IDLE) ? 32'd1 : 32'd0);
            case (m_state)
                M_IDLE: begin
                    check_eq("rsp_valid_idle", 32'(rsp_valid), 0);
                    if (mon_g >= 0) begin
                        sb.push_back('{mon_g,
                            ref_alu(req_op1[32*mon_g +: 32], req_op2[32*mon_g +: 32], req_alu_op[4*mon_g +: 4]),
                            ref_alu(req_op1[32*mon_g +: 32], req_op2[32*mon_g +: 32], req_alu_op[4*mon_g +: 4]) == 32'd0});
                        grant_log.push_back(mon_g);
                        m_rr    = (mon_g + 1) % int'(NREQ);
                        m_state = M_EXEC;
                    end
                end
                M_EXEC: begin
                    check_eq("rsp_valid_exec", 32'(rsp_valid), 0);
                    m_state = M_RESP;
                    seen    = 1'b0;
                end
                default: begin
                    if (!seen) begin
                        check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
                        if (sb.size() > 0) cur = sb.pop_front();
                        seen = 1'b1;
                    end
                    check_eq("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << cur.id));
                    check_eq("rsp_result", rsp_result, cur.res);
                    check_eq("rsp_zero", 32'(rsp_zero), 32'(cur.zero));
                    if (rsp_ready[cur.id]) m_state = M_IDLE;
                end
            endcase
        end
    end

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_op1[32*id +: 32] = a;
        req_op2[32*id +: 32] = b;
        req_alu_op[4*id +: 4] = op;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk); #2;
            if (m_state == M_IDLE && !busy && sb.size() == 0) done = 1'b1;
        end
        check_eq("idle_timeout", 32'(done), 1);
    endtask

    // Single request: raise valid, hold until accepted, then drop and drain.
    task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bit hs = 1'b0;
        @(posedge clk); #1;
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk);
            if (req_ready[id]) hs = 1'b1;
        end
        check_eq("req_accept", 32'(hs), 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ngr;
        bit  ok;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_alu_op = '0;
        rsp_ready  = '1;

        // Requesters 0 and 2 pending from reset.
        set_req(0, 32'd5, 32'd7, 4'h2);
        set_req(2, 32'hFFFF_FFFF, 32'd1, 4'h2);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_req_ready", 32'(req_ready), 0);
        grant_log.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef ALU_ARB_FIXED_PRIO_EN
        ngr = 3;
`else
        ngr = 4;
`endif
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk); #2;
            if (grant_log.size() >= ngr) ok = 1'b1;
        end
        check_eq("grant_count", 32'(ok), 1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        if (grant_log.size() >= ngr) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            check_eq("order0", 32'(grant_log[0]), 0);
            check_eq("order1", 32'(grant_log[1]), 0);
            check_eq("order2", 32'(grant_log[2]), 0);
`else
            check_eq("order0", 32'(grant_log[0]), 0);
            check_eq("order1", 32'(grant_log[1]), 2);
            check_eq("order2", 32'(grant_log[2]), 0);
            check_eq("order3", 32'(grant_log[3]), 2);
`endif
        end

        // Basic arithmetic and zero flag.
        do_req(0, 32'd5, 32'd7, 4'h2);
        check_eq("add_result", rsp_result, 32'd12);
        check_eq("add_zero", 32'(rsp_zero), 0);
        do_req(1, 32'd9, 32'd9, 4'h6);
        check_eq("sub_result", rsp_result, 32'd0);
        check_eq("sub_zero", 32'(rsp_zero), 1);

        // Illegal opcode with a stalled consumer and a competing requester.
        rsp_ready[3] = 1'b0;
        @(posedge clk); #1;
        set_req(3, 32'h1234_5678, 32'h1, 4'hF);
        req_valid[3] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (rsp_valid[3]) ok = 1'b1;
            if (req_ready[3]) begin
                @(posedge clk); #1;
                req_valid[3] = 1'b0;
                req_valid[0] = 1'b1;
            end
        end
        check_eq("stall_rsp_seen", 32'(ok), 1);
        for (int c = 0; c < 5; c++) begin
            check_eq("stall_valid", 32'(rsp_valid), 32'h8);
            check_eq("stall_result", rsp_result, 32'd0);
            check_eq("stall_zero", 32'(rsp_zero), 1);
            check_eq("stall_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready[3] = 1'b1;
        req_valid[0] = 1'b0;
        wait_idle();

        // Shifts and the remaining opcodes.
        do_req(0, 32'h8000_0000, 32'd4, 4'h8);
        check_eq("lsr", rsp_result, 32'h0800_0000);
        do_req(0, 32'd1, 32'd31, 4'h9);
        check_eq("lsl", rsp_result, 32'h8000_0000);
        do_req(2, 32'h8000_0000, 32'd4, 4'hA);
        check_eq("asr", rsp_result, 32'hF800_0000);
        do_req(1, 32'hFFFF_FFFF, 32'd1, 4'h7);
        check_eq("let", rsp_result, 32'd1);
        do_req(3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'hD);
        do_req(3, 32'hF0F0_0000, 32'h0000_0F0F, 4'h1);
        do_req(3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'h0);
        check_eq("and_zero", 32'(rsp_zero), 1);
        for (int i = 0; i < 6; i++) begin
            do_req(int'($urandom_range(0, NREQ-1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during EXEC aborts the operation.
        @(posedge clk); #1;
        set_req(0, 32'd100, 32'd1, 4'h2);
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[0]) ok = 1'b1;
        end
        check_eq("abort_accept", 32'(ok), 1);
        @(posedge clk); #1;
        check_eq("abort_busy_before", 32'(busy), 1);
        req_valid[0] = 1'b0;
        set_req(1, 32'd3, 32'd4, 4'h2);
        req_valid[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_req_ready", 32'(req_ready), 0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 0);
        check_eq("abort_rsp_result", rsp_result, 0);
        check_eq("abort_rsp_zero", 32'(rsp_zero), 0);
        check_eq("abort_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        grant_log.delete();
        rst_n = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); #2;
            if (grant_log.size() > 0) ok = 1'b1;
        end
        check_eq("post_rst_grant_seen", 32'(ok), 1);
        if (grant_log.size() > 0) check_eq("post_rst_grant", 32'(grant_log[0]), 1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_idle();
        check_eq("post_rst_result", rsp_result, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
